// File: rtl/cdc_bridge_pkg.sv
// rtl/cdc_bridge_pkg.sv - shared state encoding and default protocol bytes for the CDC register bridge
package cdc_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_EXEC_WR = 3'd3,
        ST_EXEC_RD = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RESP    = 3'd6
    } bridge_state_e;

    localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'd48000;
    localparam logic [7:0]  DEF_CMD_WR         = 8'h57;
    localparam logic [7:0]  DEF_CMD_RD         = 8'h52;
    localparam logic [7:0]  DEF_RSP_ACK        = 8'h06;
    localparam logic [7:0]  DEF_RSP_NAK        = 8'h15;

    // States in which the bridge is waiting on the host for another frame byte.
    function automatic logic accepts_byte(input bridge_state_e st);
        return (st == ST_IDLE) || (st == ST_ADDR) || (st == ST_DATA);
    endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - idle-cycle counter that flags an abandoned partial frame
module frame_timer #(
    parameter logic [15:0] LIMIT = 16'd48000
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Clear wins over counting; otherwise count one per idle cycle.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 16'd0;
        end else if (enable_i) begin
            count_d = count_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry only in an idle cycle, so a byte arriving at the limit is never lost.
    assign expire_o = enable_i && (count_q == (LIMIT - 16'd1));

endmodule

// File: rtl/cdc_reg_bridge.sv
// rtl/cdc_reg_bridge.sv - byte-stream command decoder driving a simple register bus
module cdc_reg_bridge
    import cdc_bridge_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [7:0]  CMD_WR         = DEF_CMD_WR,
    parameter logic [7:0]  CMD_RD         = DEF_CMD_RD,
    parameter logic [7:0]  RSP_ACK        = DEF_RSP_ACK,
    parameter logic [7:0]  RSP_NAK        = DEF_RSP_NAK
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] out_data_i,
    input  logic       out_valid_i,
    output logic       out_ready_o,
    output logic [7:0] in_data_o,
    output logic       in_valid_o,
    input  logic       in_ready_i,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    output logic       reg_re_o,
    input  logic [7:0] reg_rdata_i,
    output logic       timeout_o
);

    bridge_state_e state_q, state_d;
    logic          wr_flag_q, wr_flag_d;
    logic          out_ready_q, out_ready_d;
    logic          in_valid_q, in_valid_d;
    logic [7:0]    in_data_q, in_data_d;
    logic [7:0]    reg_addr_q, reg_addr_d;
    logic [7:0]    reg_wdata_q, reg_wdata_d;
    logic          reg_we_q, reg_we_d;
    logic          reg_re_q, reg_re_d;
    logic          timeout_q, timeout_d;

    logic          byte_xfer;
    logic          timer_clear;
    logic          timer_enable;
    logic          timer_expire;

    assign byte_xfer    = out_valid_i && out_ready_q;
    assign timer_clear  = (state_q == ST_IDLE) || byte_xfer;
    assign timer_enable = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && !byte_xfer;

    frame_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clear_i  (timer_clear),
        .enable_i (timer_enable),
        .expire_o (timer_expire)
    );

    // Next-state and next-output decode; outputs are derived from the next state so they are registered.
    always_comb begin
        state_d     = state_q;
        wr_flag_d   = wr_flag_q;
        in_data_d   = in_data_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (byte_xfer) begin
                    if (out_data_i == CMD_WR) begin
                        wr_flag_d = 1'b1;
                        state_d   = ST_ADDR;
                    end else if (out_data_i == CMD_RD) begin
                        wr_flag_d = 1'b0;
                        state_d   = ST_ADDR;
                    end else begin
                        in_data_d = RSP_NAK;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (byte_xfer) begin
                    reg_addr_d = out_data_i;
                    state_d    = wr_flag_q ? ST_DATA : ST_EXEC_RD;
                end else if (timer_expire) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (byte_xfer) begin
                    reg_wdata_d = out_data_i;
                    state_d     = ST_EXEC_WR;
                end else if (timer_expire) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_EXEC_WR: begin
                in_data_d = RSP_ACK;
                state_d   = ST_RESP;
            end
            ST_EXEC_RD: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                in_data_d = reg_rdata_i;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (in_valid_q && in_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // in_valid trails entry into RESP by one cycle, giving the 1/2/3-cycle response latencies.
        in_valid_d  = (state_q == ST_RESP) && (state_d == ST_RESP);
        out_ready_d = accepts_byte(state_d);
        reg_we_d    = (state_d == ST_EXEC_WR);
        reg_re_d    = (state_d == ST_EXEC_RD);
    end

    // State and registered outputs; reset drops everything, including any pending frame or response.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            wr_flag_q   <= 1'b0;
            out_ready_q <= 1'b0;
            in_valid_q  <= 1'b0;
            in_data_q   <= 8'h00;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_flag_q   <= wr_flag_d;
            out_ready_q <= out_ready_d;
            in_valid_q  <= in_valid_d;
            in_data_q   <= in_data_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            timeout_q   <= timeout_d;
        end
    end

    assign out_ready_o = out_ready_q;
    assign in_valid_o  = in_valid_q;
    assign in_data_o   = in_data_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign reg_we_o    = reg_we_q;
    assign reg_re_o    = reg_re_q;
    assign timeout_o   = timeout_q;

endmodule

// File: doc/cdc_reg_bridge.md
CDC_REG_BRIDGE -- requirements
Module: cdc_reg_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd48000, sets the number of idle clk_i cycles allowed mid-frame before the frame is abandoned.
REQ-002 Parameter CMD_WR, default 8'h57 ('W'), is the write command byte.
REQ-003 Parameter CMD_RD, default 8'h52 ('R'), is the read command byte.
REQ-004 Parameter RSP_ACK, default 8'h06, is the write-acknowledge byte; parameter RSP_NAK, default 8'h15, is the unknown-command response byte.
REQ-005 clk_i  input  1  clock, the same domain as the CDC application side.
REQ-006 rstn_i  input  1  reset, asynchronous, active-low.
REQ-007 out_data_i  input  8  byte from host (CDC out_data_o).
REQ-008 out_valid_i  input  1  host byte valid.
REQ-009 out_ready_o  output  1  bridge accepts the host byte.
REQ-010 in_data_o  output  8  response byte to host (CDC in_data_i).
REQ-011 in_valid_o  output  1  response byte valid.
REQ-012 in_ready_i  input  1  CDC accepts the response byte.
REQ-013 reg_addr_o  output  8  register address; reg_wdata_o  output  8  write data.
REQ-014 reg_we_o  output  1  one-cycle write strobe; reg_re_o  output  1  one-cycle read strobe.
REQ-015 reg_rdata_i  input  8  read data, valid exactly one cycle after reg_re_o.
REQ-016 timeout_o  output  1  one-cycle pulse when a partial frame is abandoned.

Function
REQ-017 A byte SHALL transfer on a clk_i edge where valid and ready are both high; both handshakes SHALL follow valid/ready semantics.
REQ-018 States: IDLE, ADDR, DATA, EXEC_WR, EXEC_RD, RD_WAIT, RESP; out_ready_o SHALL be high only in IDLE, ADDR and DATA.
REQ-019 IDLE: CMD_WR -> ADDR (write flag set); CMD_RD -> ADDR (write flag clear); any other byte -> RESP with in_data_o = RSP_NAK.
REQ-020 ADDR: accepted byte latched into reg_addr_o; write flag -> DATA, else -> EXEC_RD.
REQ-021 DATA: accepted byte latched into reg_wdata_o -> EXEC_WR.
REQ-022 EXEC_WR: reg_we_o high for exactly this one cycle; response = RSP_ACK -> RESP.
REQ-023 EXEC_RD: reg_re_o high for exactly this one cycle -> RD_WAIT; RD_WAIT captures reg_rdata_i as response -> RESP.
REQ-024 RESP: in_valid_o high; in_data_o stable until handshake; on handshake -> IDLE with in_valid_o low the next cycle.
REQ-025 Latency: last accepted command byte to in_valid_o high = 2 cycles for write, 3 cycles for read, 1 cycle for NAK.
REQ-026 Timeout counter (16 bit): cleared on every accepted byte and in IDLE; increments each cycle in ADDR or DATA without a transfer.
REQ-027 When the counter reaches TIMEOUT_CYCLES-1 without a transfer: -> IDLE, no register access, no response, timeout_o pulses one cycle.
REQ-028 A transfer in the same cycle the counter reaches TIMEOUT_CYCLES-1 SHALL win; the byte is processed and no timeout occurs.
REQ-029 RESP SHALL NOT time out; the bridge waits indefinitely for in_ready_i.
REQ-030 reg_addr_o and reg_wdata_o SHALL hold their last latched value between frames.

Reset
REQ-031 On rstn_i low: state IDLE, counter 0, all outputs 0 (out_ready_o, in_valid_o, in_data_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o, timeout_o).
REQ-032 Reset asserted mid-frame or in RESP SHALL discard the frame and pending response; no strobe SHALL be emitted after release until a new complete frame is received.
REQ-033 After rstn_i release, out_ready_o SHALL be high on the first clock edge.

Structure
REQ-034 The state encoding and default command/response byte constants SHALL live in a shared package, cdc_bridge_pkg.
REQ-035 The timeout counter SHALL be a sub-module, frame_timer (clear, enable, expire), and all other logic SHALL remain in cdc_reg_bridge.

Verification
REQ-036 Host sends 57 10 A5 -> reg_we_o one pulse with addr 10, wdata A5; in_data_o = 06.
REQ-037 Host sends 52 10, reg_rdata_i = 3C one cycle after reg_re_o -> in_data_o = 3C; in_valid_o rises 3 cycles after addr byte.
REQ-038 Host sends 41 -> in_data_o = 15, no strobes; in_ready_i held low 20 cycles -> in_valid_o and in_data_o stable throughout.
REQ-039 TIMEOUT_CYCLES = 8; host sends 57 then stalls -> timeout_o pulses 8 cycles after the command byte; next frame 52 20 is handled normally.
REQ-040 rstn_i pulsed between the addr and data bytes of a write -> no reg_we_o; all outputs 0 during reset; out_ready_o high after release.
REQ-041 Data byte arrives exactly at the TIMEOUT_CYCLES-1 boundary -> write completes, no timeout_o.
